// File: rtl/pipe_scoreboard_fwd_pkg.sv
// Shared types and defaults for the pipeline scoreboard / forwarding unit.
package pipe_pkg;

    localparam int unsigned DEF_NREG        = 32;
    localparam int unsigned DEF_DEPTH       = 3;
    localparam int unsigned DEF_ALU_LAT     = 1;
    localparam int unsigned DEF_LOAD_LAT    = 2;
    localparam int unsigned DEF_FLUSH_DEPTH = 2;

    // Fixed field widths keep the struct parameter-independent (NREG up to 256).
    localparam int unsigned SB_RD_W  = 8;
    localparam int unsigned SB_LAT_W = 8;

    localparam int unsigned FWD_REGFILE = 0;

    typedef struct packed {
        logic                v;
        logic [SB_RD_W-1:0]  rd;
        logic [SB_LAT_W-1:0] lat;
    } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard_fwd_if.sv
// ID-stage request and EX-side forwarding controls between decoder and scoreboard.
interface pipe_scoreboard_fwd_if #(
    parameter int unsigned REGW = 5,
    parameter int unsigned SELW = 2
);
    logic            id_valid;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_is_load;
    logic            flush;
    logic            stall;
    logic            ex_valid;
    logic [SELW-1:0] fwd_sel_a;
    logic [SELW-1:0] fwd_sel_b;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_regwrite, id_is_load, flush,
        input  stall, ex_valid, fwd_sel_a, fwd_sel_b
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_regwrite, id_is_load, flush,
        output stall, ex_valid, fwd_sel_a, fwd_sel_b
    );
endinterface

// File: rtl/pipe_scoreboard_fwd_sb_match.sv
// Priority matcher: youngest valid scoreboard entry writing the given source register.
module sb_match
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned REGW  = 5,
    parameter int unsigned SELW  = 2
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic                 use_src,
    input  logic [REGW-1:0]      src,
    output logic                 hit,
    output logic [SELW-1:0]      idx,
    output logic [SB_LAT_W-1:0]  lat
);

    // Scan oldest to youngest so the lowest index overwrites older hits.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        lat = '0;
        if (use_src && (src != '0)) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (entries[i].v && (entries[i].rd == SB_RD_W'(src))) begin
                    hit = 1'b1;
                    idx = SELW'(i);
                    lat = entries[i].lat;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard_fwd.sv
// Shift scoreboard of in-flight register writes; decides stall / forward stage / regfile
// for the instruction in ID. Optional perf counters under PIPE_SCOREBOARD_PERF_EN.
module pipe_scoreboard_fwd
    import pipe_pkg::*;
#(
    parameter int unsigned NREG        = DEF_NREG,
    parameter int unsigned REGW        = $clog2(NREG),
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ALU_LAT     = DEF_ALU_LAT,
    parameter int unsigned LOAD_LAT    = DEF_LOAD_LAT,
    parameter int unsigned FLUSH_DEPTH = DEF_FLUSH_DEPTH,
    parameter int unsigned SELW        = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_scoreboard_fwd_if.slave   bus
`ifdef PIPE_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_fwd_cnt
`endif
);

    localparam logic [SB_LAT_W-1:0] ALU_LAT_L  = SB_LAT_W'(ALU_LAT);
    localparam logic [SB_LAT_W-1:0] LOAD_LAT_L = SB_LAT_W'(LOAD_LAT);

    sb_entry_t entry_q [DEPTH];
    sb_entry_t entry_d [DEPTH];

    logic                hit_a, hit_b;
    logic [SELW-1:0]     idx_a, idx_b;
    logic [SB_LAT_W-1:0] lat_a, lat_b;
    logic [SB_LAT_W-1:0] stage_a, stage_b;
    logic                stall_a, stall_b, stall_c, issue;
    logic [SELW-1:0]     sel_a, sel_b;

    logic                ex_valid_q, ex_valid_d;
    logic [SELW-1:0]     fwd_sel_a_q, fwd_sel_a_d;
    logic [SELW-1:0]     fwd_sel_b_q, fwd_sel_b_d;

    sb_match #(.DEPTH(DEPTH), .REGW(REGW), .SELW(SELW)) u_match_rs (
        .entries (entry_q),
        .use_src (bus.id_use_rs),
        .src     (bus.id_rs),
        .hit     (hit_a),
        .idx     (idx_a),
        .lat     (lat_a)
    );

    sb_match #(.DEPTH(DEPTH), .REGW(REGW), .SELW(SELW)) u_match_rt (
        .entries (entry_q),
        .use_src (bus.id_use_rt),
        .src     (bus.id_rt),
        .hit     (hit_b),
        .idx     (idx_b),
        .lat     (lat_b)
    );

    // Hazard decision: producer at entry i is at stage i+1 when the consumer reaches EX.
    always_comb begin
        stage_a = SB_LAT_W'(idx_a) + SB_LAT_W'(1);
        stage_b = SB_LAT_W'(idx_b) + SB_LAT_W'(1);
        stall_a = hit_a && (stage_a < lat_a);
        stall_b = hit_b && (stage_b < lat_b);
        sel_a   = hit_a ? SELW'(stage_a) : SELW'(FWD_REGFILE);
        sel_b   = hit_b ? SELW'(stage_b) : SELW'(FWD_REGFILE);
        stall_c = bus.id_valid && !bus.flush && (stall_a || stall_b);
        issue   = bus.id_valid && !stall_c && !bus.flush;
    end

    // Next scoreboard contents: insert issued writer or bubble, shift, kill young on flush.
    always_comb begin
        entry_d[0] = '0;
        if (issue && bus.id_regwrite && (bus.id_rd != '0)) begin
            entry_d[0].v   = 1'b1;
            entry_d[0].rd  = SB_RD_W'(bus.id_rd);
            entry_d[0].lat = bus.id_is_load ? LOAD_LAT_L : ALU_LAT_L;
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            entry_d[i] = entry_q[i-1];
        end
        if (bus.flush) begin
            for (int i = 0; i < int'(FLUSH_DEPTH); i++) begin
                entry_d[i].v = 1'b0;
            end
        end
    end

    // EX-side controls: forward selects on issue, bubble otherwise.
    always_comb begin
        ex_valid_d  = issue;
        fwd_sel_a_d = issue ? sel_a : SELW'(FWD_REGFILE);
        fwd_sel_b_d = issue ? sel_b : SELW'(FWD_REGFILE);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
            ex_valid_q  <= 1'b0;
            fwd_sel_a_q <= '0;
            fwd_sel_b_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= entry_d[i];
            end
            ex_valid_q  <= ex_valid_d;
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.fwd_sel_a = fwd_sel_a_q;
    assign bus.fwd_sel_b = fwd_sel_b_q;

`ifdef PIPE_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (issue && ((sel_a != '0) || (sel_b != '0)) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule
